edit_field_scheduler: RTL and testbench

- Front-panel edit controller for the clock/timer display counters.
- Enters and leaves edit mode, selects which 2-digit counter field is editable, and drives the shared en_count select bus.
- Generates single-cycle enUP/enDOWN step pulses from debounced buttons, with hold-to-auto-repeat and an inactivity timeout.
- Sits between the debounced button block and all field counters.

---
 rtl/edit_field_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_edit_field_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/edit_field_scheduler.sv
// -----------------------------------------------------------------------------
// edit_field_scheduler
//   Front-panel edit controller for the clock/timer display counters. Toggles
//   edit mode, selects which 2-digit field is editable, and drives single-cycle
//   step pulses with hold-to-auto-repeat and an inactivity timeout.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_edit     debounced level; rising edge toggles edit mode
//   btn_left     debounced level; rising edge selects previous field
//   btn_right    debounced level; rising edge selects next field
//   btn_up       debounced level; increment request
//   btn_down     debounced level; decrement request
//   en_count     selected field code (1..NUM_FIELDS), 0 when not editing
//   enUP         one-cycle increment pulse
//   enDOWN       one-cycle decrement pulse
//   edit_active  high while in edit mode
//   blink        display blink enable for the selected field
// -----------------------------------------------------------------------------
module edit_field_scheduler #(
    parameter int NUM_FIELDS     = 9,
    parameter int HOLD_CYCLES    = 50000000,
    parameter int REPEAT_CYCLES  = 12500000,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int BLINK_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       edit_active,
    output logic       blink
);

    localparam int MAX_AB = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int MAX_CD = (TIMEOUT_CYCLES > BLINK_CYCLES) ? TIMEOUT_CYCLES : BLINK_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] BLINK_LAST   = CW'(BLINK_CYCLES - 1);
    localparam logic [3:0]    FIELD_MAX    = 4'(NUM_FIELDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_PRESS  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    // Next field code with wrap NUM_FIELDS -> 1.
    function automatic logic [3:0] field_inc(input logic [3:0] f);
        if (f >= FIELD_MAX) begin
            return 4'd1;
        end else begin
            return f + 4'd1;
        end
    endfunction

    // Previous field code with wrap 1 -> NUM_FIELDS.
    function automatic logic [3:0] field_dec(input logic [3:0] f);
        if (f <= 4'd1) begin
            return FIELD_MAX;
        end else begin
            return f - 4'd1;
        end
    endfunction

    state_t        state_r, state_s;
    logic [3:0]    field_r, field_s;
    logic          dir_r, dir_s;          // 1 = up, 0 = down
    logic [CW-1:0] cnt_r, cnt_s;          // timeout / hold / repeat, by state
    logic [CW-1:0] bcnt_r, bcnt_s;
    logic          blink_s;
    logic          pulse_s;
    logic [4:0]    prev_r;
    logic [4:0]    btn_s;
    logic [4:0]    rise_s;
    logic          held_s;

    // Button order: {edit, left, right, up, down}.
    assign btn_s  = {btn_edit, btn_left, btn_right, btn_up, btn_down};
    assign rise_s = btn_s & ~prev_r;
    assign held_s = dir_r ? btn_up : btn_down;

    // Next-state, field, direction and shared counter decisions.
    always_comb begin
        state_s = state_r;
        field_s = field_r;
        dir_s   = dir_r;
        cnt_s   = cnt_r;
        pulse_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s[4]) begin
                    state_s = ST_SELECT;
                    field_s = 4'd1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_SELECT: begin
                if (rise_s[4]) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (rise_s[1] && !btn_down) begin
                    pulse_s = 1'b1;
                    dir_s   = 1'b1;
                    state_s = ST_PRESS;
                    cnt_s   = CNT_ZERO;
                end else if (rise_s[0] && !btn_up) begin
                    pulse_s = 1'b1;
                    dir_s   = 1'b0;
                    state_s = ST_PRESS;
                    cnt_s   = CNT_ZERO;
                end else if (rise_s[2] && !rise_s[3]) begin
                    field_s = field_inc(field_r);
                    cnt_s   = CNT_ZERO;
                end else if (rise_s[3] && !rise_s[2]) begin
                    field_s = field_dec(field_r);
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_PRESS: begin
                if (!held_s) begin
                    state_s = ST_SELECT;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == HOLD_LAST) begin
                    pulse_s = 1'b1;
                    state_s = ST_REPEAT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!held_s) begin
                    state_s = ST_SELECT;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == REPEAT_LAST) begin
                    pulse_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Blink phase: cleared in IDLE, restarts high on entry to edit mode.
    always_comb begin
        blink_s = blink;
        bcnt_s  = bcnt_r;
        if (state_s == ST_IDLE) begin
            blink_s = 1'b0;
            bcnt_s  = CNT_ZERO;
        end else if (state_r == ST_IDLE) begin
            blink_s = 1'b1;
            bcnt_s  = CNT_ZERO;
        end else if (bcnt_r == BLINK_LAST) begin
            blink_s = ~blink;
            bcnt_s  = CNT_ZERO;
        end else begin
            bcnt_s  = bcnt_r + CNT_ONE;
        end
    end

    // State, edge-detect and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            field_r     <= 4'd1;
            dir_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            bcnt_r      <= CNT_ZERO;
            prev_r      <= 5'd0;
            en_count    <= 4'd0;
            enUP        <= 1'b0;
            enDOWN      <= 1'b0;
            edit_active <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state_r     <= state_s;
            field_r     <= field_s;
            dir_r       <= dir_s;
            cnt_r       <= cnt_s;
            bcnt_r      <= bcnt_s;
            prev_r      <= btn_s;
            en_count    <= (state_s == ST_IDLE) ? 4'd0 : field_s;
            enUP        <= pulse_s & dir_s;
            enDOWN      <= pulse_s & ~dir_s;
            edit_active <= (state_s != ST_IDLE);
            blink       <= blink_s;
        end
    end

endmodule

// File: tb/tb_edit_field_scheduler.sv
module tb_edit_field_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_edit = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       edit_active;
    logic       blink;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       up;
        logic       down;
        logic [3:0] en;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    edit_field_scheduler #(
        .NUM_FIELDS(9),
        .HOLD_CYCLES(4),
        .REPEAT_CYCLES(2),
        .TIMEOUT_CYCLES(20),
        .BLINK_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_edit(btn_edit),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .en_count(en_count),
        .enUP(enUP),
        .enDOWN(enDOWN),
        .edit_active(edit_active),
        .blink(blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse(input int c, input logic up, input logic [3:0] en);
        exp_t e;
        e.cyc  = c;
        e.up   = up;
        e.down = ~up;
        e.en   = en;
        exp_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: every enUP/enDOWN must match the next queued expectation.
    always @(negedge clk) begin
        if (enUP || enDOWN) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'({enUP, enDOWN}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_kind", int'({enUP, enDOWN, en_count}),
                      int'({mon_e.up, mon_e.down, mon_e.en}));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check("pulse_present", int'(enUP | enDOWN), 1);
        end
    end

    int c;
    int e;

    initial begin
        ticks(2);
        check("reset_outputs", int'({en_count, enUP, enDOWN, edit_active, blink}), 0);
        reset = 1'b0;
        ticks(1);

        // Entry and blink phase
        btn_edit = 1'b1;
        ticks(1);
        check("entry_active", int'(edit_active), 1);
        check("entry_field", int'(en_count), 1);
        check("entry_blink", int'(blink), 1);
        btn_edit = 1'b0;
        ticks(2);
        check("blink_still_high", int'(blink), 1);
        ticks(1);
        check("blink_toggled", int'(blink), 0);

        // Field wrap right, then left at 1
        for (int i = 1; i <= 9; i++) begin
            btn_right = 1'b1;
            ticks(1);
            check("right_step", int'(en_count), (i % 9) + 1);
            btn_right = 1'b0;
            ticks(1);
        end
        btn_left = 1'b1;
        ticks(1);
        check("left_wrap", int'(en_count), 9);
        btn_left = 1'b0;
        ticks(1);

        // Single step
        push_pulse(cyc + 1, 1'b1, 4'd9);
        btn_up = 1'b1;
        ticks(2);
        btn_up = 1'b0;
        ticks(2);
        check("single_field", int'(en_count), 9);
        check("single_active", int'(edit_active), 1);

        // Auto-repeat down: pulses at +1, +5, +7, +9, none on release
        c = cyc;
        push_pulse(c + 1, 1'b0, 4'd9);
        push_pulse(c + 5, 1'b0, 4'd9);
        push_pulse(c + 7, 1'b0, 4'd9);
        push_pulse(c + 9, 1'b0, 4'd9);
        btn_down = 1'b1;
        ticks(10);
        btn_down = 1'b0;
        ticks(3);

        // Up and down together: no pulse
        btn_up = 1'b1;
        btn_down = 1'b1;
        ticks(3);
        btn_up = 1'b0;
        btn_down = 1'b0;
        ticks(2);
        check("both_dir_active", int'(edit_active), 1);

        // btn_right during REPEAT is ignored
        c = cyc;
        push_pulse(c + 1, 1'b1, 4'd9);
        push_pulse(c + 5, 1'b1, 4'd9);
        push_pulse(c + 7, 1'b1, 4'd9);
        btn_up = 1'b1;
        ticks(5);
        btn_right = 1'b1;
        ticks(2);
        btn_up = 1'b0;
        ticks(2);
        btn_right = 1'b0;
        ticks(1);
        check("right_in_repeat", int'(en_count), 9);

        // Edit and right together -> IDLE
        btn_edit = 1'b1;
        btn_right = 1'b1;
        ticks(1);
        check("edit_prio", int'({en_count, edit_active, blink}), 0);
        btn_edit = 1'b0;
        btn_right = 1'b0;
        ticks(1);

        // Plain timeout
        btn_edit = 1'b1;
        ticks(1);
        btn_edit = 1'b0;
        ticks(19);
        check("timeout_not_yet", int'(edit_active), 1);
        ticks(1);
        check("timeout_exit", int'({en_count, edit_active, blink}), 0);
        ticks(1);

        // Timeout restart by a right rise at cycle 15
        btn_edit = 1'b1;
        ticks(1);
        e = cyc;
        btn_edit = 1'b0;
        ticks(14);
        btn_right = 1'b1;
        ticks(1);
        check("restart_field", int'(en_count), 2);
        btn_right = 1'b0;
        ticks(19);
        check("restart_still_active", int'(edit_active), 1);
        ticks(1);
        check("restart_timeout_exit", int'(edit_active), 0);
        ticks(1);

        // Async reset during REPEAT
        btn_edit = 1'b1;
        ticks(1);
        btn_edit = 1'b0;
        ticks(1);
        c = cyc;
        push_pulse(c + 1, 1'b1, 4'd1);
        push_pulse(c + 5, 1'b1, 4'd1);
        btn_up = 1'b1;
        ticks(6);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", int'({en_count, enUP, enDOWN, edit_active, blink}), 0);
        ticks(2);
        reset = 1'b0;
        btn_up = 1'b0;
        ticks(1);
        btn_edit = 1'b1;
        ticks(1);
        check("post_reset_field", int'(en_count), 1);
        check("post_reset_active", int'(edit_active), 1);
        btn_edit = 1'b0;
        ticks(3);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
